// File: rtl/hier_pipe_pkg.sv
// Shared types, sizes and helpers for the hierarchical_pipe responder.
// HIER_PIPE_ACTIVITY_EN (top level) enables the result toggle-activity counter.
package hier_pipe_pkg;

   localparam int OPERAND_W      = 4;
   localparam int CNT_W          = 16;
   localparam int DEF_FIFO_DEPTH = 2;

   typedef logic [OPERAND_W-1:0] operand_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < CNT_W; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/hier_result_fifo.sv
// Small first-word-fall-through result FIFO: the head entry is visible on dout
// the cycle after it is written. Pointers carry one extra wrap bit.
module hier_result_fifo
   import hier_pipe_pkg::*;
#(
   parameter int WIDTH = OPERAND_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem_reg [DEPTH];

   // Entries are reset so the head reads 0 straight out of reset.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_reg[gi] <= '0;
         end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
            mem_reg[gi] <= din;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign dout  = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/hierarchical_pipe.sv
// Two-stage (a+b)*(c-d) responder with handshaked input and a result FIFO.
// Define HIER_PIPE_ACTIVITY_EN to build the result toggle-activity counter.
module hierarchical_pipe
   import hier_pipe_pkg::*;
#(
   parameter int WIDTH      = OPERAND_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] act_count
);

   logic               s1_valid_reg;
   logic               s2_valid_reg;
   logic [WIDTH-1:0]   sum_ab_reg;
   logic [WIDTH-1:0]   diff_cd_reg;
   logic [WIDTH-1:0]   prod_reg;
   logic [2*WIDTH-1:0] prod_full;
   logic [CNT_W-1:0]   count_reg;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               push;
   logic               space;
   logic               adv;
   logic               accept;

   // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
   assign pop       = out_valid && out_ready;
   assign space     = !fifo_full || pop;
   assign adv       = !s2_valid_reg || space;
   assign push      = s2_valid_reg && space;
   assign in_ready  = !s1_valid_reg || adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = !fifo_empty;
   assign prod_full = sum_ab_reg * diff_cd_reg;
   assign count     = count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         sum_ab_reg   <= '0;
         diff_cd_reg  <= '0;
         prod_reg     <= '0;
         count_reg    <= '0;
      end else begin
         if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            prod_reg     <= prod_full[WIDTH-1:0];
         end
         // S1 also refills when it is empty even though S2 is stalled.
         if (in_ready) begin
            s1_valid_reg <= in_valid;
            sum_ab_reg   <= a + b;
            diff_cd_reg  <= c - d;
         end
         if (accept) count_reg <= count_reg + CNT_W'(1);
      end
   end

   hier_result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (prod_reg),
      .dout  (result),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef HIER_PIPE_ACTIVITY_EN
   logic [WIDTH-1:0] prev_reg;
   logic [CNT_W-1:0] act_reg;
   logic [CNT_W:0]   act_sum;

   assign act_sum   = {1'b0, act_reg} + {1'b0, popcount(CNT_W'(prod_reg ^ prev_reg))};
   assign act_count = act_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_reg <= '0;
         act_reg  <= '0;
      end else if (push) begin
         prev_reg <= prod_reg;
         act_reg  <= act_sum[CNT_W] ? '1 : act_sum[CNT_W-1:0];
      end
   end
`else
   assign act_count = '0;
`endif

endmodule
